// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU among NREQ requesters.
// Operands are latched at accept, executed from registers, result held until taken.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero,
  output logic              busy,
  output logic [IDXW-1:0]   grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  logic [IDXW-1:0] last_grant;
  logic [31:0]     op_a;
  logic [31:0]     op_b;
  logic [2:0]      op_op;

  logic [IDXW-1:0] gsel;
  logic            found;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [2:0]      sel_op;
  logic [31:0]     alu_y;
  logic            alu_z;
  logic            rsp_ack;

  // Rotating priority: ports above last_grant first, then wrap to the low ones
  always_comb begin
    gsel  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && IDXW'(i) > last_grant) begin
        gsel  = IDXW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && IDXW'(i) <= last_grant) begin
        gsel  = IDXW'(i);
        found = 1'b1;
      end
    end
  end

  // Operand mux for the port being accepted
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gsel == IDXW'(i)) begin
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
        sel_op = req_op[3*i +: 3];
      end
    end
  end

  // Shared ALU, fed only from the latched operand registers
  always_comb begin
    alu_y = '0;
    unique case (op_op)
      3'b000: alu_y = op_a + op_b;
      3'b001: alu_y = op_a - op_b;
      3'b010: alu_y = op_a & op_b;
      3'b011: alu_y = op_a | op_b;
      3'b100: alu_y = op_a ^ op_b;
      3'b101: alu_y = {31'b0, op_a < op_b};
      3'b110: alu_y = op_a << op_b;
      3'b111: alu_y = op_a >> op_b;
    endcase
    alu_z = (alu_y == 32'b0);
  end

  // Handshake outputs; ready only in IDLE, response only in RESP
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !reset && state == IDLE && found && gsel == IDXW'(i);
      rsp_valid[i] = state == RESP && grant_id == IDXW'(i);
    end
    rsp_ack = |(rsp_valid & rsp_ready);
    busy    = state != IDLE;
  end

  // Sequencer: accept, execute one cycle, hold response until taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDXW'(NREQ - 1);
      grant_id   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_op      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a     <= sel_a;
            op_b     <= sel_b;
            op_op    <= sel_op;
            grant_id <= gsel;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_y;
          rsp_zero   <= alu_z;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ack) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
